// File: rtl/scalarmult_fixed_window.sv
// Fixed-window scalar multiplication controller: walks the scalar WIN bits at a
// time and accumulates precomputed table[j][digit_j] points through an external
// point adder. Accumulator is held in extended coordinates (x, y, t, z).
// Optional build macro: SCALARMULT_ZERO_SKIP_EN skips additions for zero digits
// (except the last window, which always issues so the affine request is honoured).
module scalarmult_fixed_window #(
  parameter int unsigned FW    = 255,
  parameter int unsigned NBITS = 255,
  parameter int unsigned WIN   = 4,
  localparam int unsigned NWIN = (NBITS + WIN - 1) / WIN,
  localparam int unsigned AW   = $clog2(NWIN) + WIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] k_in,
  input  logic             affine,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             busy,
  input  logic             abort,
  output logic [FW-1:0]    px,
  output logic [FW-1:0]    py,
  output logic [FW-1:0]    pt,
  output logic [FW-1:0]    pz,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [AW-1:0]    rom_addr,
  input  logic [FW-1:0]    rom_x,
  input  logic [FW-1:0]    rom_y,
  input  logic [FW-1:0]    rom_t,
  output logic [FW-1:0]    pa_x1,
  output logic [FW-1:0]    pa_y1,
  output logic [FW-1:0]    pa_t1,
  output logic [FW-1:0]    pa_z1,
  output logic [FW-1:0]    pa_x2,
  output logic [FW-1:0]    pa_y2,
  output logic [FW-1:0]    pa_t2,
  output logic [FW-1:0]    pa_z2,
  output logic             pa_affine,
  output logic             pa_req_valid,
  input  logic             pa_req_ready,
  input  logic [FW-1:0]    pa_x3,
  input  logic [FW-1:0]    pa_y3,
  input  logic [FW-1:0]    pa_t3,
  input  logic [FW-1:0]    pa_z3,
  input  logic             pa_res_valid,
  output logic             pa_res_ready
);

  localparam int unsigned KW = NWIN * WIN;       // scalar zero-extended to whole windows
  localparam int unsigned JW = $clog2(NWIN + 1); // window counter must be able to hold NWIN

  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_LOAD0, S_FETCH, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;            // remaining digits, next window in the low WIN bits
  logic            aff_q, aff_d;
  logic [JW-1:0]   j_q, j_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [FW-1:0]   px_q, px_d, py_q, py_d, pt_q, pt_d, pz_q, pz_d;
  logic [FW-1:0]   pa_x2_q, pa_x2_d, pa_y2_q, pa_y2_d, pa_t2_q, pa_t2_d;
  logic            pa_affine_q, pa_affine_d;
  logic            pa_req_valid_q, pa_req_valid_d;
  logic            pa_res_ready_q, pa_res_ready_d;
  logic            pend_q, pend_d;      // an accepted addition whose result is still owed
  logic            req_ready_q, req_ready_d;
  logic            busy_q, busy_d;
  logic            res_valid_q, res_valid_d;

  logic [KW-1:0]   k_ext;
  logic [JW-1:0]   next_j;
  logic            last_win;

  assign k_ext    = KW'(k_in);
  assign next_j   = j_q + JW'(1);
  assign last_win = (j_q == JW'(NWIN - 1));

  // Next-state, datapath and handshake logic
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    aff_d          = aff_q;
    j_d            = j_q;
    rom_addr_d     = rom_addr_q;
    px_d           = px_q;
    py_d           = py_q;
    pt_d           = pt_q;
    pz_d           = pz_q;
    pa_x2_d        = pa_x2_q;
    pa_y2_d        = pa_y2_q;
    pa_t2_d        = pa_t2_q;
    pa_affine_d    = pa_affine_q;
    pa_req_valid_d = pa_req_valid_q;
    pa_res_ready_d = 1'b0;
    pend_d         = pend_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          aff_d      = affine;
          j_d        = '0;
          rom_addr_d = AW'(k_ext[WIN-1:0]);
          k_d        = k_ext >> WIN;
          state_d    = S_PRELOAD;
        end
      end
      S_PRELOAD: state_d = S_LOAD0;
      S_LOAD0: begin
        px_d = rom_x;
        py_d = rom_y;
        pt_d = rom_t;
        pz_d = FW'(1);
        j_d  = JW'(1);
        if (NWIN == 1) begin
          state_d = S_DONE;
        end else begin
          rom_addr_d = AW'({next_j, k_q[WIN-1:0]});
          k_d        = k_q >> WIN;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
`ifdef SCALARMULT_ZERO_SKIP_EN
        // zero digit adds the identity; move on unless this is the final window
        if ((rom_addr_q[WIN-1:0] == '0) && !last_win) begin
          j_d        = next_j;
          rom_addr_d = AW'({next_j, k_q[WIN-1:0]});
          k_d        = k_q >> WIN;
        end else begin
          state_d = S_ISSUE;
        end
`else
        state_d = S_ISSUE;
`endif
      end
      S_ISSUE: begin
        if (pa_req_valid_q) begin
          if (pa_req_ready) begin
            pa_req_valid_d = 1'b0;
            pa_affine_d    = 1'b0;
            state_d        = S_WAIT;
          end
        end else if (!pend_q) begin
          // table data is valid now; snapshot it so the request stays stable
          pa_x2_d        = rom_x;
          pa_y2_d        = rom_y;
          pa_t2_d        = rom_t;
          pa_affine_d    = last_win & aff_q;
          pa_req_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (pend_q && pa_res_valid) begin
          px_d = pa_x3;
          py_d = pa_y3;
          pt_d = pa_t3;
          pz_d = pa_z3;
          j_d  = next_j;
          if (next_j == JW'(NWIN)) begin
            state_d = S_DONE;
          end else begin
            rom_addr_d = AW'({next_j, k_q[WIN-1:0]});
            k_d        = k_q >> WIN;
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q inside {S_PRELOAD, S_LOAD0, S_FETCH, S_ISSUE, S_WAIT})) begin
      state_d        = S_IDLE;
      pa_req_valid_d = 1'b0;
      pa_affine_d    = 1'b0;
    end

    // owed results are always consumed, even after an abort
    if (pend_q && pa_res_valid) begin
      pend_d         = 1'b0;
      pa_res_ready_d = 1'b1;
    end
    if (pa_req_valid_q && pa_req_ready) pend_d = 1'b1;

    req_ready_d = (state_d == S_IDLE);
    busy_d      = state_d inside {S_PRELOAD, S_LOAD0, S_FETCH, S_ISSUE, S_WAIT};
    res_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      aff_q          <= 1'b0;
      j_q            <= '0;
      rom_addr_q     <= '0;
      px_q           <= '0;
      py_q           <= FW'(1);
      pt_q           <= '0;
      pz_q           <= FW'(1);
      pa_x2_q        <= '0;
      pa_y2_q        <= '0;
      pa_t2_q        <= '0;
      pa_affine_q    <= 1'b0;
      pa_req_valid_q <= 1'b0;
      pa_res_ready_q <= 1'b0;
      pend_q         <= 1'b0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      res_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      aff_q          <= aff_d;
      j_q            <= j_d;
      rom_addr_q     <= rom_addr_d;
      px_q           <= px_d;
      py_q           <= py_d;
      pt_q           <= pt_d;
      pz_q           <= pz_d;
      pa_x2_q        <= pa_x2_d;
      pa_y2_q        <= pa_y2_d;
      pa_t2_q        <= pa_t2_d;
      pa_affine_q    <= pa_affine_d;
      pa_req_valid_q <= pa_req_valid_d;
      pa_res_ready_q <= pa_res_ready_d;
      pend_q         <= pend_d;
      req_ready_q    <= req_ready_d;
      busy_q         <= busy_d;
      res_valid_q    <= res_valid_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign res_valid    = res_valid_q;
  assign rom_addr     = rom_addr_q;
  assign px           = px_q;
  assign py           = py_q;
  assign pt           = pt_q;
  assign pz           = pz_q;
  assign pa_x1        = px_q;
  assign pa_y1        = py_q;
  assign pa_t1        = pt_q;
  assign pa_z1        = pz_q;
  assign pa_x2        = pa_x2_q;
  assign pa_y2        = pa_y2_q;
  assign pa_t2        = pa_t2_q;
  assign pa_z2        = FW'(1);
  assign pa_affine    = pa_affine_q;
  assign pa_req_valid = pa_req_valid_q;
  assign pa_res_ready = pa_res_ready_q;

endmodule

// File: tb/tb_scalarmult_fixed_window.sv
// Bench for scalarmult_fixed_window. The table and adder stubs use a toy
// additive group: point for value v is (v, 1+2v, 3v, z); the adder sums
// x and t, combines y as y1+y2-1 and returns z1+z2 (or 1 when affine), so the
// non-affine z reports 1 + number of additions performed.
module tb_scalarmult_fixed_window;
  localparam int unsigned FW    = 255;
  localparam int unsigned NBITS = 255;
  localparam int unsigned WIN   = 4;
  localparam int unsigned NWIN  = (NBITS + WIN - 1) / WIN;
  localparam int unsigned AW    = $clog2(NWIN) + WIN;

  logic clk = 1'b0;
  logic rst;
  logic [NBITS-1:0] k_in;
  logic affine, req_valid, req_ready, busy, abort;
  logic [FW-1:0] px, py, pt, pz;
  logic res_valid, res_ready;
  logic [AW-1:0] rom_addr;
  logic [FW-1:0] rom_x, rom_y, rom_t;
  logic [FW-1:0] pa_x1, pa_y1, pa_t1, pa_z1, pa_x2, pa_y2, pa_t2, pa_z2;
  logic pa_affine, pa_req_valid, pa_req_ready;
  logic [FW-1:0] pa_x3, pa_y3, pa_t3, pa_z3;
  logic pa_res_valid, pa_res_ready;

  int checks = 0;
  int errors = 0;

  int req_dly = 0, res_dly = 0;
  int n_add = 0, n_aff = 0, n_ack = 0, hold_err = 0, drop_cnt = 0;
  logic last_aff = 1'b0;

  always #5 clk = ~clk;

  scalarmult_fixed_window #(.FW(FW), .NBITS(NBITS), .WIN(WIN)) dut (
    .clk(clk), .rst(rst), .k_in(k_in), .affine(affine),
    .req_valid(req_valid), .req_ready(req_ready), .busy(busy), .abort(abort),
    .px(px), .py(py), .pt(pt), .pz(pz),
    .res_valid(res_valid), .res_ready(res_ready),
    .rom_addr(rom_addr), .rom_x(rom_x), .rom_y(rom_y), .rom_t(rom_t),
    .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_t1(pa_t1), .pa_z1(pa_z1),
    .pa_x2(pa_x2), .pa_y2(pa_y2), .pa_t2(pa_t2), .pa_z2(pa_z2),
    .pa_affine(pa_affine), .pa_req_valid(pa_req_valid), .pa_req_ready(pa_req_ready),
    .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_t3(pa_t3), .pa_z3(pa_z3),
    .pa_res_valid(pa_res_valid), .pa_res_ready(pa_res_ready)
  );

  function automatic logic [FW-1:0] rom_val(input logic [AW-1:0] a);
    logic [FW-1:0] d;
    d = FW'(a[WIN-1:0]);
    return d << (WIN * (a >> WIN));
  endfunction

  function automatic logic [FW-1:0] ey(input logic [NBITS-1:0] k);
    return FW'(1) + (FW'(k) << 1);
  endfunction

  function automatic logic [FW-1:0] et(input logic [NBITS-1:0] k);
    return FW'(k) + (FW'(k) << 1);
  endfunction

  function automatic int exp_adds(input logic [NBITS-1:0] k);
`ifdef SCALARMULT_ZERO_SKIP_EN
    int n;
    logic [NWIN*WIN-1:0] kk;
    n  = 1;
    kk = (NWIN*WIN)'(k);
    for (int j = 1; j < int'(NWIN) - 1; j++) if (kk[WIN*j +: WIN] != '0) n++;
    return n;
`else
    return int'(NWIN) - 1;
`endif
  endfunction

  // synchronous table ROM, one cycle of latency
  always @(posedge clk) begin
    rom_x <= rom_val(rom_addr);
    rom_y <= FW'(1) + (rom_val(rom_addr) << 1);
    rom_t <= rom_val(rom_addr) + (rom_val(rom_addr) << 1);
  end

  // point-adder stub with programmable accept and result delays
  initial begin : adder_model
    logic [FW-1:0] ax1, ay1, at1, az1, ax2, ay2, at2, az2;
    logic aaff, ok;
    int cnt;
    pa_req_ready = 1'b0; pa_res_valid = 1'b0;
    pa_x3 = '0; pa_y3 = '0; pa_t3 = '0; pa_z3 = '0;
    forever begin
      @(negedge clk);
      if (!rst && pa_req_valid) begin
        ax1 = pa_x1; ay1 = pa_y1; at1 = pa_t1; az1 = pa_z1;
        ax2 = pa_x2; ay2 = pa_y2; at2 = pa_t2; az2 = pa_z2;
        aaff = pa_affine; ok = 1'b1;
        for (int i = 0; i < req_dly && ok; i++) begin
          @(negedge clk);
          if (rst) ok = 1'b0;
          else if (!pa_req_valid) begin drop_cnt++; ok = 1'b0; end
          else if (pa_x1 !== ax1 || pa_x2 !== ax2 || pa_t2 !== at2 || pa_affine !== aaff) hold_err++;
        end
        if (ok) begin
          pa_req_ready = 1'b1;
          @(negedge clk);
          pa_req_ready = 1'b0;
          n_add++;
          if (aaff) n_aff++;
          last_aff = aaff;
          for (int i = 0; i < res_dly && ok; i++) begin
            @(negedge clk);
            if (rst) ok = 1'b0;
          end
          if (ok) begin
            pa_x3 = ax1 + ax2;
            pa_y3 = ay1 + ay2 - FW'(1);
            pa_t3 = at1 + at2;
            pa_z3 = aaff ? FW'(1) : az1 + az2;
            pa_res_valid = 1'b1;
            cnt = 0;
            while (ok && cnt < 100) begin
              @(negedge clk);
              cnt++;
              if (rst) ok = 1'b0;
              else if (pa_res_ready) begin n_ack++; cnt = 1000; end
            end
            pa_res_valid = 1'b0;
          end
        end
      end
    end
  end

  // one full request/response; DUT must be idle on entry
  task automatic run_op(input logic [NBITS-1:0] k, input logic aff, input int rdly,
                        output logic tmo, output logic [FW-1:0] rx, output logic [FW-1:0] ry,
                        output logic [FW-1:0] rt, output logic [FW-1:0] rz, output int hold_bad);
    int cnt;
    @(negedge clk);
    k_in = k; affine = aff; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (!res_valid && cnt < 3000) begin @(negedge clk); cnt++; end
    tmo = !res_valid;
    rx = px; ry = py; rt = pt; rz = pz;
    hold_bad = 0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      if (!res_valid || px !== rx || py !== ry || pt !== rt || pz !== rz) hold_bad++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, busy, res_valid, pa_req_valid, pa_res_ready, pa_affine} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 100000",
        {req_ready, busy, res_valid, pa_req_valid, pa_res_ready, pa_affine});
    end
    checks++; if (px !== FW'(0)) begin errors++; $display("FAIL reset_px got %0h exp 0", px); end
    checks++; if (py !== FW'(1)) begin errors++; $display("FAIL reset_py got %0h exp 1", py); end
    checks++; if (pt !== FW'(0)) begin errors++; $display("FAIL reset_pt got %0h exp 0", pt); end
    checks++; if (pz !== FW'(1)) begin errors++; $display("FAIL reset_pz got %0h exp 1", pz); end
  endtask

  task automatic test_k1();
    logic tmo; logic [FW-1:0] rx, ry, rt, rz; int hb, a0, f0;
    a0 = n_add; f0 = n_aff;
    run_op(NBITS'(1), 1'b0, 0, tmo, rx, ry, rt, rz, hb);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL k1_timeout got %b exp 0", tmo); end
    checks++; if (rx !== FW'(1)) begin errors++; $display("FAIL k1_x got %0h exp 1", rx); end
    checks++; if (ry !== FW'(3)) begin errors++; $display("FAIL k1_y got %0h exp 3", ry); end
    checks++; if (rt !== FW'(3)) begin errors++; $display("FAIL k1_t got %0h exp 3", rt); end
    checks++; if (rz !== FW'(1 + exp_adds(NBITS'(1)))) begin
      errors++; $display("FAIL k1_z got %0h exp %0h", rz, 1 + exp_adds(NBITS'(1))); end
    checks++; if (n_add - a0 != exp_adds(NBITS'(1))) begin
      errors++; $display("FAIL k1_adds got %0d exp %0d", n_add - a0, exp_adds(NBITS'(1))); end
    checks++; if (n_aff - f0 != 0) begin errors++; $display("FAIL k1_affine_cnt got %0d exp 0", n_aff - f0); end
    checks++; if ({res_valid, req_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL k1_release got %b exp 010", {res_valid, req_ready, busy}); end
  endtask

  task automatic test_k0();
    logic tmo; logic [FW-1:0] rx, ry, rt, rz; int hb;
    run_op(NBITS'(0), 1'b0, 0, tmo, rx, ry, rt, rz, hb);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL k0_timeout got %b exp 0", tmo); end
    checks++; if ({rx, ry, rt} !== {FW'(0), FW'(1), FW'(0)}) begin
      errors++; $display("FAIL k0_identity got %0h/%0h/%0h exp 0/1/0", rx, ry, rt); end
    checks++; if (rz !== FW'(1 + exp_adds(NBITS'(0)))) begin
      errors++; $display("FAIL k0_z got %0h exp %0h", rz, 1 + exp_adds(NBITS'(0))); end
  endtask

  task automatic test_affine();
    logic tmo; logic [FW-1:0] rx, ry, rt, rz; int hb, a0, f0;
    logic [NBITS-1:0] k;
    k = (NBITS'(1) << 252) + NBITS'(5);
    a0 = n_add; f0 = n_aff;
    run_op(k, 1'b1, 0, tmo, rx, ry, rt, rz, hb);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL aff_timeout got %b exp 0", tmo); end
    checks++; if (rx !== FW'(k)) begin errors++; $display("FAIL aff_x got %0h exp %0h", rx, k); end
    checks++; if (ry !== ey(k) || rt !== et(k)) begin
      errors++; $display("FAIL aff_yt got %0h/%0h exp %0h/%0h", ry, rt, ey(k), et(k)); end
    checks++; if (rz !== FW'(1)) begin errors++; $display("FAIL aff_z got %0h exp 1", rz); end
    checks++; if (n_aff - f0 != 1 || last_aff !== 1'b1) begin
      errors++; $display("FAIL aff_flag got cnt %0d last %b exp cnt 1 last 1", n_aff - f0, last_aff); end
    checks++; if (n_add - a0 != exp_adds(k)) begin
      errors++; $display("FAIL aff_adds got %0d exp %0d", n_add - a0, exp_adds(k)); end
  endtask

  task automatic test_backpressure();
    logic tmo; logic [FW-1:0] rx, ry, rt, rz; int hb, h0, d0;
    h0 = hold_err; d0 = drop_cnt;
    req_dly = 5;
    run_op(NBITS'(16'h1234), 1'b0, 10, tmo, rx, ry, rt, rz, hb);
    req_dly = 0;
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b exp 0", tmo); end
    checks++; if (rx !== FW'(16'h1234) || ry !== ey(NBITS'(16'h1234))) begin
      errors++; $display("FAIL bp_result got %0h/%0h exp 1234/%0h", rx, ry, ey(NBITS'(16'h1234))); end
    checks++; if (hb != 0) begin errors++; $display("FAIL bp_res_hold got %0d exp 0", hb); end
    checks++; if (hold_err - h0 != 0 || drop_cnt - d0 != 0) begin
      errors++; $display("FAIL bp_req_hold got %0d/%0d exp 0/0", hold_err - h0, drop_cnt - d0); end
  endtask

  task automatic test_busy_ignore();
    int cnt;
    @(negedge clk);
    k_in = NBITS'(6); affine = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if ({busy, req_ready} !== 2'b10) begin
      errors++; $display("FAIL busy_flags got %b exp 10", {busy, req_ready}); end
    k_in = NBITS'(9); req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (!res_valid && cnt < 3000) begin @(negedge clk); cnt++; end
    checks++; if (res_valid !== 1'b1 || px !== FW'(6)) begin
      errors++; $display("FAIL busy_ignore got valid %b x %0h exp valid 1 x 6", res_valid, px); end
    // request while a result waits is dropped as well
    k_in = NBITS'(9); req_valid = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    checks++; if (res_valid !== 1'b1 || px !== FW'(6)) begin
      errors++; $display("FAIL done_ignore got valid %b x %0h exp valid 1 x 6", res_valid, px); end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic tmo; logic [FW-1:0] rx, ry, rt, rz; int hb;
    run_op(NBITS'(12'hF10), 1'b0, 0, tmo, rx, ry, rt, rz, hb);
    checks++; if (tmo !== 1'b0 || rx !== FW'(12'hF10)) begin
      errors++; $display("FAIL b2b_first got tmo %b x %0h exp tmo 0 x f10", tmo, rx); end
    run_op(NBITS'(12'h0A7), 1'b0, 0, tmo, rx, ry, rt, rz, hb);
    checks++; if (tmo !== 1'b0 || rx !== FW'(12'h0A7) || rt !== et(NBITS'(12'h0A7))) begin
      errors++; $display("FAIL b2b_second got tmo %b x %0h t %0h exp tmo 0 x a7 t %0h",
                         tmo, rx, rt, et(NBITS'(12'h0A7))); end
  endtask

  task automatic test_abort();
    logic tmo; logic [FW-1:0] rx, ry, rt, rz; int hb, a0, k0, cnt, rv;
    a0 = n_add; k0 = n_ack;
    res_dly = 20;
    @(negedge clk);
    k_in = '1; affine = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (n_add < a0 + 10 && cnt < 1000) begin @(negedge clk); cnt++; end
    checks++; if (n_add != a0 + 10) begin errors++; $display("FAIL abort_reach got %0d exp %0d", n_add - a0, 10); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if ({busy, pa_req_valid, req_ready, res_valid} !== 4'b0010) begin
      errors++; $display("FAIL abort_flags got %b exp 0010", {busy, pa_req_valid, req_ready, res_valid}); end
    rv = 0;
    repeat (40) begin @(negedge clk); if (res_valid !== 1'b0) rv++; end
    checks++; if (rv != 0) begin errors++; $display("FAIL abort_no_result got %0d exp 0", rv); end
    checks++; if (n_ack - k0 != 10) begin errors++; $display("FAIL abort_drain got %0d exp 10", n_ack - k0); end
    res_dly = 0;
    run_op(NBITS'(3), 1'b0, 0, tmo, rx, ry, rt, rz, hb);
    checks++; if (tmo !== 1'b0 || rx !== FW'(3) || ry !== FW'(7) || rt !== FW'(9)) begin
      errors++; $display("FAIL abort_k3 got tmo %b %0h/%0h/%0h exp 0 3/7/9", tmo, rx, ry, rt); end
  endtask

  task automatic test_reset_mid();
    logic tmo; logic [FW-1:0] rx, ry, rt, rz; int hb, a0, cnt;
    req_dly = 5;
    @(negedge clk);
    k_in = '1; affine = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (!pa_req_valid && cnt < 100) begin @(negedge clk); cnt++; end
    checks++; if (pa_req_valid !== 1'b1) begin errors++; $display("FAIL rmid_issue got %b exp 1", pa_req_valid); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, busy, res_valid, pa_req_valid, pa_res_ready, pa_affine} !== 6'b100000) begin
      errors++; $display("FAIL rmid_ctrl got %b exp 100000",
        {req_ready, busy, res_valid, pa_req_valid, pa_res_ready, pa_affine});
    end
    checks++; if ({px, py, pt, pz} !== {FW'(0), FW'(1), FW'(0), FW'(1)}) begin
      errors++; $display("FAIL rmid_point got %0h/%0h/%0h/%0h exp 0/1/0/1", px, py, pt, pz); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_dly = 0;
    a0 = n_add;
    run_op(NBITS'(7), 1'b0, 0, tmo, rx, ry, rt, rz, hb);
    checks++; if (tmo !== 1'b0 || rx !== FW'(7) || rz !== FW'(1 + exp_adds(NBITS'(7)))) begin
      errors++; $display("FAIL rmid_fresh got tmo %b x %0h z %0h exp 0 7 %0h",
                         tmo, rx, rz, 1 + exp_adds(NBITS'(7))); end
    checks++; if (n_add - a0 != exp_adds(NBITS'(7))) begin
      errors++; $display("FAIL rmid_adds got %0d exp %0d", n_add - a0, exp_adds(NBITS'(7))); end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; k_in = '0; affine = 1'b0; req_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_k1();
    test_k0();
    test_affine();
    test_backpressure();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scalarmult_fixed_window.md
SCALARMULT_FIXED_WINDOW -- requirements
Module: scalarmult_fixed_window

Interface
REQ-001 Parameter: FW, 255, field-element width of point coordinates.
REQ-002 Parameter: NBITS, 255, scalar width.
REQ-003 Parameter: WIN, 4, window width in bits (legal 2..6).
REQ-004 Derived: NWIN = ceil(NBITS/WIN); AW = clog2(NWIN)+WIN.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  async active-high reset.
REQ-008 k_in  in  NBITS  scalar; affine  in  1  request affine result.
REQ-009 req_valid in 1 / req_ready out 1: request handshake; busy out 1 high from accept to res_valid.
REQ-010 abort  in  1  cancel current operation.
REQ-011 px, py, pt, pz  out  FW each  result point (extended coordinates).
REQ-012 res_valid out 1 / res_ready in 1: result handshake.
REQ-013 rom_addr out AW = {window index, digit}; rom_x, rom_y, rom_t in FW each; data valid 1 cycle after rom_addr, table z = 1.
REQ-014 pa_x1..pa_z1, pa_x2..pa_z2 out FW each; pa_affine out 1; pa_req_valid out 1 / pa_req_ready in 1; pa_x3..pa_z3 in FW each; pa_res_valid in 1 / pa_res_ready out 1: external point-adder port.

Function
REQ-015 SHALL compute k_in*B as the sum over j = 0..NWIN-1 of table[j][digit_j], digit_j = k[WIN*j+WIN-1 : WIN*j], k zero-extended to NWIN*WIN bits.
REQ-016 States SHALL be IDLE, PRELOAD, LOAD0, FETCH, ISSUE, WAIT, DONE.
REQ-017 IDLE: req_ready=1; req_valid -> latch k_in and affine, window index j=0, busy=1, req_ready=0 -> PRELOAD.
REQ-018 PRELOAD: drive rom_addr={0,digit_0}; next cycle (LOAD0) capture rom data into px/py/pt, pz=1, j=1.
REQ-019 NWIN=1 SHALL go LOAD0 -> DONE with no addition.
REQ-020 FETCH: drive rom_addr={j,digit_j}; ISSUE: present accumulator as pa_*1, rom data as pa_*2 (z2=1), pa_req_valid=1 held until pa_req_ready sampled high.
REQ-021 pa_affine SHALL equal latched affine on the j=NWIN-1 addition, else 0.
REQ-022 WAIT: on pa_res_valid capture pa_*3 into accumulator, pulse pa_res_ready one cycle, j=j+1; j=NWIN -> DONE, else FETCH.
REQ-023 DONE: res_valid=1, busy=0; held with px..pz stable until res_ready sampled high -> IDLE next cycle.
REQ-024 abort in PRELOAD..WAIT SHALL return to IDLE next cycle, deassert pa_req_valid and busy, never assert res_valid; an issued addition's result SHALL be consumed (pa_res_ready pulsed) and discarded if it arrives later. abort in IDLE/DONE ignored.
REQ-025 req_valid while busy or in DONE SHALL be ignored.
REQ-026 Window index SHALL not wrap; ROM addresses j >= NWIN never driven.

Reset
REQ-027 rst SHALL force state IDLE, req_ready=1, busy=0, res_valid=0, pa_req_valid=0, pa_res_ready=0, pa_affine=0, px=0, py=1, pt=0, pz=1, j=0, within the reset cycle asynchronously.
REQ-028 rst mid-operation SHALL discard all progress; first post-reset request computes from scratch.

Configuration
REQ-029 Macro SCALARMULT_ZERO_SKIP_EN defined: in FETCH, digit_j=0 with j<NWIN-1 SHALL skip the addition (j=j+1, no pa_req_valid); the j=NWIN-1 addition SHALL always be issued so affine is honoured.
REQ-030 Macro undefined: every window j=1..NWIN-1 SHALL issue exactly one addition; results identical in both builds.

Verification
REQ-031 WIN=4, k=1, affine=0, stub adder: result = table[0][1] = B; 63 additions (macro off), 1 addition (macro on).
REQ-032 k=0: result identity (0,1,0,1) with z as returned by adder; table[0][0] row used.
REQ-033 k=2^252+5, affine=1: result matches software model in affine form (pz=1); pa_affine high only on last addition.
REQ-034 pa_req_ready delayed 5 cycles, res_ready delayed 10 cycles: pa_req_valid and res_valid held, outputs stable.
REQ-035 abort during WAIT of window 10, late pa_res_valid: result discarded, no res_valid; next request k=3 returns 3B.
REQ-036 rst asserted in ISSUE: all outputs at REQ-027 values same cycle; WIN=2 and WIN=6 regressions pass.
